// File: rtl/conv_layer_sequencer_if.sv
// Accelerator mode encoding plus the descriptor-SRAM / accelerator-control bundle
// driven by conv_layer_sequencer (master) and served by the SRAM and accelerator (slave).
package conv_acc_pkg;
   typedef enum logic [1:0] {
      IDLE_MODE     = 2'd0,
      CONV_3x3_MODE = 2'd1,
      CONV_1x1_MODE = 2'd2,
      MAX_POOL_MODE = 2'd3
   } conv_acc_mode_t;
endpackage

interface conv_layer_sequencer_if #(parameter int DESC_AW = 8);
   import conv_acc_pkg::*;

   logic               desc_cs;
   logic [DESC_AW-1:0] desc_addr;
   logic [31:0]        desc_rdata;
   conv_acc_mode_t     acc_mode;
   logic [31:0]        acc_w8;
   logic               acc_start;
   logic               acc_finish;

   modport master (
      output desc_cs, desc_addr, acc_mode, acc_w8, acc_start,
      input  desc_rdata, acc_finish
   );

   modport slave (
      input  desc_cs, desc_addr, acc_mode, acc_w8, acc_start,
      output desc_rdata, acc_finish
   );
endinterface

// File: rtl/conv_layer_sequencer.sv
// Walks a two-word-per-layer descriptor table and runs the conv accelerator once per layer.
// Optional SEQ_PERF_EN adds last_cycles / total_cycles performance counters.
module conv_layer_sequencer
   import conv_acc_pkg::*;
#(
   parameter int DESC_AW = 8,
   parameter int LAYER_W = 7
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [LAYER_W-1:0] num_layers,
   input  logic [DESC_AW-1:0] base_addr,
   output logic               busy,
   output logic               done,
   output logic               err,
   output logic [LAYER_W-1:0] layer_idx,
`ifdef SEQ_PERF_EN
   output logic [31:0]        last_cycles,
   output logic [31:0]        total_cycles,
`endif
   conv_layer_sequencer_if.master bus
);

   typedef enum logic [2:0] {
      S_IDLE, S_RD0, S_RD1, S_LAT, S_GO, S_RUN, S_NXT, S_DONE
   } state_t;

   state_t             state;
   logic [LAYER_W-1:0] n_q;
   logic [DESC_AW-1:0] base_q;
   logic [1:0]         mode_q;

   logic [LAYER_W-1:0] idx_inc;
   logic               last_layer;

   // First descriptor word of layer k; wraps silently modulo 2^DESC_AW.
   function automatic logic [DESC_AW-1:0] word0(input logic [DESC_AW-1:0] b,
                                                input logic [LAYER_W-1:0] k);
      return b + DESC_AW'({k, 1'b0});
   endfunction

   assign idx_inc    = layer_idx + LAYER_W'(1);
   // A zero-layer run passes through NXT only to give busy its one cycle.
   assign last_layer = (n_q == '0) || (idx_inc == n_q);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         // NOTE: sequential state uses non-blocking assignments only, and every
         // register (outputs included) has an async reset so desc_cs drops at once.
         state          <= S_IDLE;
         n_q            <= '0;
         base_q         <= '0;
         mode_q         <= '0;
         busy           <= 1'b0;
         done           <= 1'b0;
         err            <= 1'b0;
         layer_idx      <= '0;
         bus.desc_cs    <= 1'b0;
         bus.desc_addr  <= '0;
         bus.acc_mode   <= IDLE_MODE;
         bus.acc_w8     <= '0;
         bus.acc_start  <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  n_q       <= num_layers;
                  base_q    <= base_addr;
                  err       <= 1'b0;
                  busy      <= 1'b1;
                  layer_idx <= '0;
                  if (num_layers == '0) begin
                     state <= S_NXT;
                  end else begin
                     state         <= S_RD0;
                     bus.desc_cs   <= 1'b1;
                     bus.desc_addr <= base_addr;
                  end
               end
            end
            S_RD0: begin
               state         <= S_RD1;
               bus.desc_addr <= bus.desc_addr + DESC_AW'(1);
            end
            S_RD1: begin
               mode_q      <= bus.desc_rdata[1:0];
               bus.desc_cs <= 1'b0;
               state       <= S_LAT;
            end
            S_LAT: begin
               bus.acc_w8 <= bus.desc_rdata;
               if (mode_q == 2'd0) begin
                  err   <= 1'b1;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= S_DONE;
               end else begin
                  bus.acc_mode  <= conv_acc_mode_t'(mode_q);
                  bus.acc_start <= 1'b1;
                  state         <= S_GO;
               end
            end
            S_GO: begin
               bus.acc_start <= 1'b0;
               state         <= S_RUN;
            end
            S_RUN: begin
               // Mode and w8 stay put here: the accelerator selects its finish by mode.
               if (bus.acc_finish) begin
                  bus.acc_mode <= IDLE_MODE;
                  state        <= S_NXT;
               end
            end
            S_NXT: begin
               if (n_q != '0) layer_idx <= idx_inc;
               if (last_layer) begin
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= S_DONE;
               end else begin
                  bus.desc_cs   <= 1'b1;
                  bus.desc_addr <= word0(base_q, idx_inc);
                  state         <= S_RD0;
               end
            end
            S_DONE: begin
               done         <= 1'b0;
               bus.acc_mode <= IDLE_MODE;
               state        <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

`ifdef SEQ_PERF_EN
   logic [31:0] run_cnt;
   logic [31:0] tot_cnt;

   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == '1) ? v : v + 32'd1;
   endfunction

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         run_cnt      <= '0;
         tot_cnt      <= '0;
         last_cycles  <= '0;
         total_cycles <= '0;
      end else if (state == S_IDLE) begin
         if (start) begin
            run_cnt      <= '0;
            tot_cnt      <= '0;
            last_cycles  <= '0;
            total_cycles <= '0;
         end
      end else begin
         tot_cnt <= sat_inc(tot_cnt);
         if (state == S_GO)       run_cnt <= '0;
         else if (state == S_RUN) run_cnt <= sat_inc(run_cnt);
         if (state == S_NXT && n_q != '0) last_cycles  <= run_cnt;
         // Counts the DONE cycle itself, so the value is start-to-done distance.
         if (state == S_DONE)              total_cycles <= sat_inc(tot_cnt);
      end
   end
`endif

endmodule

// File: tb/tb_conv_layer_sequencer.sv
// Self-checking bench for conv_layer_sequencer: a timeline model derived from the
// layer latencies predicts every output per cycle; directed runs pin the model with literals.
module tb_conv_layer_sequencer;
   import conv_acc_pkg::*;

   localparam int DESC_AW = 8;
   localparam int LAYER_W = 7;
   localparam int MAXC    = 1024;
   localparam int MAXL    = 8;

   logic               clk = 1'b0;
   logic               rst;
   logic               start;
   logic [LAYER_W-1:0] num_layers;
   logic [DESC_AW-1:0] base_addr;
   logic               busy, done, err;
   logic [LAYER_W-1:0] layer_idx;
`ifdef SEQ_PERF_EN
   logic [31:0]        last_cycles, total_cycles;
`endif

   conv_layer_sequencer_if #(.DESC_AW(DESC_AW)) bus ();

   conv_layer_sequencer #(.DESC_AW(DESC_AW), .LAYER_W(LAYER_W)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .num_layers (num_layers),
      .base_addr  (base_addr),
      .busy       (busy),
      .done       (done),
      .err        (err),
      .layer_idx  (layer_idx),
`ifdef SEQ_PERF_EN
      .last_cycles  (last_cycles),
      .total_cycles (total_cycles),
`endif
      .bus        (bus)
   );

   always #5 clk = ~clk;

   // Descriptor SRAM: one-cycle read latency.
   logic [31:0] mem [0:255];
   always @(posedge clk) if (bus.desc_cs) bus.desc_rdata <= mem[bus.desc_addr];

   int n_checks = 0;
   int n_err    = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Scenario description
   int          sc_n, sc_base;
   int          sc_mode  [MAXL];
   logic [31:0] sc_w8    [MAXL];
   int          sc_delay [MAXL];
   int          sc_extra [MAXL];
   bit          sc_hold;

   // Predicted per-cycle outputs (cycle 0 = the cycle start is driven)
   bit          e_cs [MAXC], e_start [MAXC], e_busy [MAXC], e_done [MAXC], e_err [MAXC];
   bit          e_win [MAXC], f_sched [MAXC];
   int          e_addr [MAXC], e_mode [MAXC], e_idx [MAXC];
   logic [31:0] e_w8 [MAXC];
   int          done_t, horizon;
   bit          err_prev = 1'b0;

   // Observations used by the literal pins
   int o_done_cnt, o_done_t, o_starts, o_busy_cnt, o_cs_cnt;
   int o_addr [$];
   int o_start_t [$];

   task automatic set_layer(input int k, input int mode, input logic [31:0] w8,
                            input int delay, input int extra);
      sc_mode[k] = mode; sc_w8[k] = w8; sc_delay[k] = delay; sc_extra[k] = extra;
   endtask

   // Layer k starts at go; finish seen at go+delay; next go five cycles later,
   // done two cycles after the last finish; reads occupy go-3 and go-2.
   task automatic build_model();
      int t, fin, err_from;
      for (int i = 0; i < MAXC; i++) begin
         e_cs[i] = 0; e_start[i] = 0; e_busy[i] = 0; e_done[i] = 0; e_win[i] = 0;
         e_addr[i] = 0; e_mode[i] = 0; e_idx[i] = 0; e_w8[i] = '0;
         f_sched[i] = sc_hold;
      end
      err_from = MAXC;
      t = 4;
      done_t = 2;
      for (int k = 0; k < sc_n; k++) begin
         e_cs[t-3] = 1; e_addr[t-3] = (sc_base + 2*k) % 256;
         e_cs[t-2] = 1; e_addr[t-2] = (sc_base + 2*k + 1) % 256;
         if (sc_mode[k] == 0) begin
            done_t = t; err_from = t;
            break;
         end
         fin = t + sc_delay[k];
         e_start[t] = 1;
         for (int c = t; c <= fin; c++) begin
            e_win[c] = 1; e_mode[c] = sc_mode[k]; e_w8[c] = sc_w8[k]; e_idx[c] = k;
         end
         if (!sc_hold) for (int c = fin; c <= fin + sc_extra[k]; c++) f_sched[c] = 1;
         if (k == sc_n - 1) done_t = fin + 2;
         else t = fin + 5;
      end
      for (int c = 1; c < done_t; c++) e_busy[c] = 1;
      e_done[done_t] = 1;
      e_err[0] = err_prev;
      for (int c = 1; c < MAXC; c++) e_err[c] = (c >= err_from);
      horizon = done_t + 3;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, ".busy"},      32'(busy), 0);
      check({tag, ".done"},      32'(done), 0);
      check({tag, ".err"},       32'(err), 0);
      check({tag, ".layer_idx"}, 32'(layer_idx), 0);
      check({tag, ".desc_cs"},   32'(bus.desc_cs), 0);
      check({tag, ".acc_start"}, 32'(bus.acc_start), 0);
      check({tag, ".acc_mode"},  32'(bus.acc_mode), 32'(IDLE_MODE));
      check({tag, ".acc_w8"},    bus.acc_w8, 0);
   endtask

   // Called at posedge+1; returns at posedge+1. abort_at < 0 means no reset.
   task automatic run_seq(input int abort_at);
      logic [31:0] r;
      build_model();
      for (int k = 0; k < sc_n; k++) begin
         r = $urandom();
         r[1:0] = 2'(sc_mode[k]);
         mem[(sc_base + 2*k) % 256]     = r;
         mem[(sc_base + 2*k + 1) % 256] = sc_w8[k];
      end
      o_done_cnt = 0; o_done_t = -1; o_starts = 0; o_busy_cnt = 0; o_cs_cnt = 0;
      o_addr.delete(); o_start_t.delete();
      for (int t = 0; t <= horizon; t++) begin
         start          = (t == 0) ? 1'b1 : ((t <= done_t) ? 1'($urandom_range(0, 1)) : 1'b0);
         num_layers     = (t == 0) ? LAYER_W'(sc_n) : LAYER_W'($urandom());
         base_addr      = (t == 0) ? DESC_AW'(sc_base) : DESC_AW'($urandom());
         bus.acc_finish = f_sched[t];
         if (t == abort_at) begin
            start = 1'b0;
            rst   = 1'b1;
            #1;
            check_reset_outputs($sformatf("rst_mid@%0d", t));
            @(posedge clk); #1;
            rst = 1'b0;
            bus.acc_finish = 1'b0;
            err_prev = 1'b0;
            return;
         end
         @(negedge clk);
         check($sformatf("busy@%0d", t),      32'(busy), 32'(e_busy[t]));
         check($sformatf("done@%0d", t),      32'(done), 32'(e_done[t]));
         check($sformatf("err@%0d", t),       32'(err), 32'(e_err[t]));
         check($sformatf("desc_cs@%0d", t),   32'(bus.desc_cs), 32'(e_cs[t]));
         check($sformatf("acc_start@%0d", t), 32'(bus.acc_start), 32'(e_start[t]));
         check($sformatf("acc_mode@%0d", t),  32'(bus.acc_mode), 32'(e_mode[t]));
         if (e_cs[t])  check($sformatf("desc_addr@%0d", t), 32'(bus.desc_addr), 32'(e_addr[t]));
         if (e_win[t]) begin
            check($sformatf("acc_w8@%0d", t),    bus.acc_w8, e_w8[t]);
            check($sformatf("layer_idx@%0d", t), 32'(layer_idx), 32'(e_idx[t]));
         end
         if (done)          begin o_done_cnt++; o_done_t = t; end
         if (bus.acc_start) begin o_starts++; o_start_t.push_back(t); end
         if (busy)          o_busy_cnt++;
         if (bus.desc_cs)   begin o_cs_cnt++; o_addr.push_back(int'(bus.desc_addr)); end
         @(posedge clk); #1;
      end
      start = 1'b0;
      bus.acc_finish = 1'b0;
      err_prev = e_err[horizon];
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; num_layers = '0; base_addr = '0; bus.acc_finish = 1'b0;
      for (int i = 0; i < 256; i++) mem[i] = '0;
      repeat (2) @(negedge clk);
      check_reset_outputs("reset");
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;

      // Three layers at 0x10, finish 20 cycles after each start
      sc_n = 3; sc_base = 'h10; sc_hold = 0;
      set_layer(0, 1, 32'hA, 20, 0);
      set_layer(1, 2, 32'hB, 20, 0);
      set_layer(2, 3, 32'hC, 20, 0);
      run_seq(-1);
      check("t1.starts", o_starts, 3);
      if (o_start_t.size() == 3) begin
         check("t1.start0", o_start_t[0], 4);
         check("t1.start1", o_start_t[1], 29);
         check("t1.start2", o_start_t[2], 54);
      end
      check("t1.done_cnt", o_done_cnt, 1);
      check("t1.done_t", o_done_t, 76);
      check("t1.reads", o_addr.size(), 6);
      for (int i = 0; i < o_addr.size() && i < 6; i++)
         check($sformatf("t1.addr%0d", i), o_addr[i], 'h10 + i);
      check("t1.err", 32'(err), 0);

      // Zero layers
      sc_n = 0; sc_base = 'h33;
      run_seq(-1);
      check("t2.cs_cnt", o_cs_cnt, 0);
      check("t2.starts", o_starts, 0);
      check("t2.done_t", o_done_t, 2);
      check("t2.busy_cnt", o_busy_cnt, 1);

      // Illegal mode in layer 1 aborts after its descriptor read
      sc_n = 3; sc_base = 'h40;
      set_layer(0, 2, 32'h1234_5678, 5, 1);
      set_layer(1, 0, 32'hDEAD_BEEF, 5, 0);
      set_layer(2, 1, 32'h0000_0001, 5, 0);
      run_seq(-1);
      check("t3.starts", o_starts, 1);
      check("t3.done_t", o_done_t, 14);
      check("t3.done_cnt", o_done_cnt, 1);
      check("t3.err_sticky", 32'(err), 1);

      // Address wrap past 0xFF; this start also clears the sticky err
      sc_n = 2; sc_base = 'hFE;
      set_layer(0, 3, 32'h0F0F_0F0F, 3, 2);
      set_layer(1, 1, 32'hF0F0_F0F0, 3, 0);
      run_seq(-1);
      check("t4.reads", o_addr.size(), 4);
      if (o_addr.size() == 4) begin
         check("t4.addr0", o_addr[0], 'hFE);
         check("t4.addr1", o_addr[1], 'hFF);
         check("t4.addr2", o_addr[2], 'h00);
         check("t4.addr3", o_addr[3], 'h01);
      end
      check("t4.err", 32'(err), 0);

      // acc_finish held high the whole time
      sc_n = 2; sc_base = 'h80; sc_hold = 1;
      set_layer(0, 2, 32'h55, 1, 0);
      set_layer(1, 3, 32'h66, 1, 0);
      run_seq(-1);
      check("t5.starts", o_starts, 2);
      if (o_start_t.size() == 2) begin
         check("t5.start0", o_start_t[0], 4);
         check("t5.start1", o_start_t[1], 10);
      end
      check("t5.done_t", o_done_t, 13);
      sc_hold = 0;

      // Reset during RUN of layer 1, then a fresh run from layer 0
      sc_n = 3; sc_base = 'h20;
      set_layer(0, 1, 32'h11, 10, 0);
      set_layer(1, 2, 32'h22, 10, 0);
      set_layer(2, 3, 32'h33, 10, 0);
      run_seq(22);
      check("t6.no_done", o_done_cnt, 0);
      check("t6.starts_before_rst", o_starts, 2);
      run_seq(-1);
      check("t6.restart_addr0", (o_addr.size() > 0) ? o_addr[0] : -1, 'h20);
      check("t6.restart_starts", o_starts, 3);

      // Randomized runs
      for (int it = 0; it < 12; it++) begin
         sc_n    = $urandom_range(0, 5);
         sc_base = $urandom_range(0, 255);
         sc_hold = ($urandom_range(0, 4) == 0);
         for (int k = 0; k < MAXL; k++)
            set_layer(k, ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 3), $urandom(),
                      sc_hold ? 1 : $urandom_range(1, 25), $urandom_range(0, 3));
         run_seq(-1);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: got simulation still running expected finish");
      $fatal(1, "timeout");
   end
endmodule
